// File: rtl/inv_shiftrows_subbytes_seq.sv
// Sequential InvShiftRows + InvSubBytes stage of the AES decryption round.
// InvShiftRows is applied at capture; LANES bytes per cycle then pass through inverse S-boxes.
module inv_shiftrows_subbytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  localparam int unsigned NSTEP = 16 / LANES;
  localparam int unsigned CntW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  // Inverse S-box, entry b lives at bits [8b +: 8]
  localparam logic [0:2047] InvSboxTab = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTab[{b, 3'b000} +: 8];
  endfunction

  // out[r][c] = in[r][(c - r) mod 4], byte index k = r + 4c
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [0:127]    work_q, work_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[l] = inv_sbox(lane_in[l]);
  end

  // in_ready depends combinationally on out_ready so DONE can hand off and recapture in one edge
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_state = work_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StSub;
          cnt_d   = '0;
          work_d  = inv_shift_rows(in_state);
        end
      end
      StSub: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(int'(cnt_q)*LANES + l) +: 8] = lane_out[l];
        end
        if (cnt_q == CntW'(NSTEP - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = StSub;
            cnt_d   = '0;
            work_d  = inv_shift_rows(in_state);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_subbytes_seq.sv
// Bench for inv_shiftrows_subbytes_seq: LANES=4, 1 and 16 instances checked against a
// transaction model built from GF(2^8) arithmetic, plus directed literal expectations.
module tb_inv_shiftrows_subbytes_seq;

  localparam logic [127:0] C1In  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] C1Out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] Z52   = {16{8'h52}};

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [0:127] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] out_state [3];
  logic         busy      [3];

  int nstep [3] = '{4, 16, 1};
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]   inv_tab [256];
  logic         have    [3] = '{default: 1'b0};
  logic         clean   [3] = '{default: 1'b1};
  logic [127:0] exp_st  [3];
  int           rdy_at  [3];

  inv_shiftrows_subbytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0])
  );
  inv_shiftrows_subbytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1])
  );
  inv_shiftrows_subbytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from its definition; the inverse table is its preimage map
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] q;
    q = 8'h01;
    for (int i = 0; i < 254; i++) q = gmul(q, x);
    return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
  endfunction

  // Byte k of the state is the k-th byte from the left of the hex literal
  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8*(r + 4*c) -: 8] = inv_tab[x[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]];
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    logic ev;
    logic rdy;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        have[i]  = 1'b0;
        clean[i] = 1'b1;
        chk($sformatf("dut%0d_rst_out_valid", i), out_valid[i], 0);
        chk($sformatf("dut%0d_rst_busy", i), busy[i], 0);
        chk($sformatf("dut%0d_rst_out_state", i), out_state[i], 0);
      end else begin
        ev  = have[i] && (cyc >= rdy_at[i]);
        rdy = !have[i] || (ev && out_ready[i]);
        chk($sformatf("dut%0d_out_valid", i), out_valid[i], ev);
        chk($sformatf("dut%0d_busy", i), busy[i], have[i]);
        chk($sformatf("dut%0d_in_ready", i), in_ready[i], rdy);
        if (ev) chk($sformatf("dut%0d_out_state", i), out_state[i], exp_st[i]);
        else if (clean[i]) chk($sformatf("dut%0d_out_state_clean", i), out_state[i], 0);
        if (ev && out_ready[i]) have[i] = 1'b0;
        if (in_valid[i] && rdy) begin
          have[i]   = 1'b1;
          clean[i]  = 1'b0;
          exp_st[i] = model(in_state[i]);
          rdy_at[i] = cyc + 1 + nstep[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int second;
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
    chk("model_zero", model('0), Z52);
    chk("model_c1", model(C1In), C1Out);

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_state[i]  = '0;
      out_ready[i] = 1'b1;
    end
    out_ready[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("idle_in_ready", in_ready[0], 1);
    chk("idle_out_valid", out_valid[0], 0);

    // All-zero block with LANES=4: four cycles of latency, then held under backpressure
    in_valid[0] = 1'b1;
    in_state[0] = '0;
    tick();
    in_valid[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("lat4_valid", out_valid[0], (k == 4));
    end
    chk("zero_result", out_state[0], Z52);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", out_valid[0], 1);
      chk("bp_hold", out_state[0], Z52);
      chk("bp_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready[0], 1);
    tick();
    chk("bp_done_valid", out_valid[0], 0);
    chk("bp_done_busy", busy[0], 0);

    // FIPS-197 C.1 round 1 on every lane count
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b1;
      in_state[i] = C1In;
    end
    tick();
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("c1_valid_dut%0d", i), out_valid[i], (k == nstep[i]));
        if (k == nstep[i]) chk($sformatf("c1_result_dut%0d", i), out_state[i], C1Out);
      end
    end

    // Back-to-back: second block captured on the DONE handshake edge
    in_valid[0] = 1'b1;
    in_state[0] = C1In;
    tick();
    in_state[0] = '0;
    first = -1;
    second = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (out_valid[0]) begin
        if (first < 0) begin
          first = k;
          chk("b2b_first_data", out_state[0], C1Out);
        end else begin
          second = k;
          chk("b2b_second_data", out_state[0], Z52);
        end
      end
      if (k == 5) in_valid[0] = 1'b0;
    end
    chk("b2b_first_cycle", first, 4);
    chk("b2b_gap", second - first, 5);

    // Asynchronous reset with cnt == 2
    in_valid[0] = 1'b1;
    in_state[0] = C1In;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid[0], 0);
    chk("mid_rst_state", out_state[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    in_valid[0] = 1'b1;
    in_state[0] = C1In;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    chk("post_rst_valid", out_valid[0], 1);
    chk("post_rst_result", out_state[0], C1Out);
    tick();

    // in_valid pulsed during SUB must be ignored
    in_valid[0] = 1'b1;
    in_state[0] = C1In;
    tick();
    in_state[0] = {16{8'hff}};
    tick();
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    chk("sub_pulse_valid", out_valid[0], 1);
    chk("sub_pulse_result", out_state[0], C1Out);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
